// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit and its helpers.
//   XLEN             : architectural address/instruction width
//   INSTR_BYTES      : bytes per instruction (PC increment)
//   RESET_PC_DEFAULT : default fetch address after reset
//   NOP_INSTR        : canonical NOP encoding (addi x0, x0, 0)
package cpu_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response channel.
//   imem_req_valid / imem_req_addr : fetch request, held until accepted
//   imem_req_ready                 : memory accepts the request
//   imem_rsp_valid / imem_rsp_data : in-order instruction return, no backpressure
// master = fetch unit side, slave = instruction memory side.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = cpu_pkg::XLEN
) ();

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between fetch and decode.
//   clk, reset : clock and synchronous active-high reset
//   i_push     : write i_data (ignored when full unless popping in the same cycle)
//   i_pop      : drop the head entry (ignored when empty)
//   i_flush    : empty the FIFO; takes precedence over push and pop
//   o_data     : head entry (registered storage, no bypass from i_data)
//   o_count    : current occupancy
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * XLEN,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word-aligned fetches to imem, buffers in-order
// responses as {pc, instr} for decode, and restarts on redirects while discarding in-flight work.
//   clk, reset      : clock and synchronous active-high reset
//   redirect_valid  : restart fetch at redirect_pc (bits [1:0] forced to zero)
//   redirect_pc     : new fetch address
//   imem            : request/response channel to instruction memory (master side)
//   if_valid        : fetch buffer head valid
//   if_pc/if_instr  : head PC and instruction (zero while empty)
//   if_ready        : decode consumes head
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN       = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     MAX_OUTST  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    instr_fetch_unit_if.master         imem,
    output logic                       if_valid,
    output logic [XLEN-1:0]            if_pc,
    output logic [XLEN-1:0]            if_instr,
    input  logic                       if_ready
);

    localparam int unsigned     OW      = $clog2(MAX_OUTST + 1);
    localparam int unsigned     CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_rsp_pc;
    logic [OW-1:0]     r_outst;
    logic [OW-1:0]     r_drop;

    logic [OW-1:0]     w_live;
    logic [31:0]       w_credit;
    logic              w_issue;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [OW-1:0]     w_rsp;
    logic [2*XLEN-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;

    // Requests still owed to the FIFO: in flight minus those already marked for discard.
    assign w_live   = r_outst - r_drop;
    assign w_credit = 32'(w_count) + 32'(w_live);
    assign w_issue  = !reset && !redirect_valid && (32'(r_outst) < MAX_OUTST)
                      && (w_credit < FIFO_DEPTH);
    assign w_accept = w_issue && imem.imem_req_ready;
    assign w_rsp    = OW'(imem.imem_rsp_valid);
    assign w_push   = imem.imem_rsp_valid && !redirect_valid && (r_drop == '0);
    assign w_pop    = !w_empty && if_ready && !redirect_valid;

    assign imem.imem_req_valid = w_issue;
    assign imem.imem_req_addr  = r_fetch_pc;

    assign if_valid = !w_empty;
    assign if_pc    = w_empty ? '0 : w_head[2*XLEN-1:XLEN];
    assign if_instr = w_empty ? '0 : w_head[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            // Nothing issues this cycle, so every request left in flight is stale.
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_rsp_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
            r_outst    <= r_outst - w_rsp;
            r_drop     <= r_outst - w_rsp;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            r_outst <= r_outst + OW'(w_accept) - w_rsp;
            if (imem.imem_rsp_valid) begin
                if (r_drop != '0) begin
                    r_drop <= r_drop - OW'(1);
                end else begin
                    r_rsp_pc <= r_rsp_pc + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, imem.imem_rsp_data}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The credit check must make a push into a full, non-draining buffer impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        int          lat;
        int          pre;
        bit          do_rd;
        logic [31:0] rpc;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b1;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_accept = 0;
    bit          popped;
    bit          want_first;
    logic [31:0] first_addr;
    logic [31:0] last_pc;
    logic [31:0] exp_pc;
    mreq_t       mq[$];
    vec_t        vecs[5];
    logic [31:0] got[4];
    int          k;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0013_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock cycle: drive memory response, observe handshakes, advance to next negedge.
    task automatic step();
        int    e;
        bit    rsp_fire;
        mreq_t m;
        e = cyc + 1;
        rsp_fire = 1'b0;
        popped = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (!reset && mq.size() > 0 && mq[0].due == e) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memfn(mq[0].addr);
            rsp_fire = 1'b1;
        end
        #1;
        if (!reset) begin
            if (redirect_valid) begin
                check("redirect_no_issue", {31'b0, bus.imem_req_valid}, 32'h0);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (want_first) begin
                    check("first_fetch_addr", bus.imem_req_addr, first_addr);
                    want_first = 1'b0;
                end
                m.addr = bus.imem_req_addr;
                m.due  = e + lat;
                mq.push_back(m);
                n_accept++;
            end
            if (if_valid && if_ready && !redirect_valid) begin
                check("if_pc", if_pc, exp_pc);
                check("if_instr", if_instr, memfn(exp_pc));
                last_pc = if_pc;
                popped = 1'b1;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                first_addr = exp_pc;
                want_first = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        if (rsp_fire) begin
            void'(mq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int l);
        lat = l;
        reset = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0);
        mq.delete();
        exp_pc = '0;
        n_accept = 0;
        want_first = 1'b0;
        reset = 1'b0;
    endtask

    // Collect up to n pops into got[], bounded by a cycle budget.
    task automatic collect(input int n, input string name);
        k = 0;
        for (int t = 0; t < 80 && k < n; t++) begin
            step();
            if (popped) begin
                got[k] = last_pc;
                k++;
            end
        end
        if (k < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pops expected %0d", name, k, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        want_first = 1'b0;
        exp_pc = '0;
        @(negedge clk);

        // Table: latency, cycles before redirect, redirect?, target, first three PCs after it.
        vecs[0] = '{1, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        vecs[1] = '{3, 2, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vecs[2] = '{1, 3, 1'b1, 32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
        vecs[3] = '{1, 0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{2, 5, 1'b1, 32'h0000_0041, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048};

        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].lat);
            if_ready = 1'b1;
            repeat (vecs[i].pre) step();
            if (vecs[i].do_rd) begin
                redirect_valid = 1'b1;
                redirect_pc    = vecs[i].rpc;
                step();
                redirect_valid = 1'b0;
            end
            collect(3, "vec");
            if (k == 3) begin
                check("vec_pc0", got[0], vecs[i].e0);
                check("vec_pc1", got[1], vecs[i].e1);
                check("vec_pc2", got[2], vecs[i].e2);
            end
        end

        // Back-to-back redirects: the last target wins.
        do_reset(2);
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0500;
        step();
        redirect_pc = 32'h0000_0600;
        step();
        redirect_valid = 1'b0;
        collect(2, "b2b");
        if (k == 2) begin
            check("b2b_pc0", got[0], 32'h0000_0600);
            check("b2b_pc1", got[1], 32'h0000_0604);
        end

        // Decode stalled: buffer fills to exactly FIFO_DEPTH and fetch stops, then drains in order.
        do_reset(1);
        if_ready = 1'b0;
        repeat (20) step();
        check("bp_accepts", n_accept, 32'd4);
        check("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        check("bp_if_valid", {31'b0, if_valid}, 32'h1);
        check("bp_head_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        collect(4, "bp");
        if (k == 4) begin
            check("bp_pc0", got[0], 32'h0);
            check("bp_pc1", got[1], 32'h4);
            check("bp_pc2", got[2], 32'h8);
            check("bp_pc3", got[3], 32'hC);
        end

        // Reset while work is buffered and in flight.
        do_reset(3);
        if_ready = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        check("mid_rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("mid_rst_req_addr", bus.imem_req_addr, 32'h0);
        check("mid_rst_if_pc", if_pc, 32'h0);
        check("mid_rst_if_instr", if_instr, 32'h0);
        mq.delete();
        exp_pc = '0;
        want_first = 1'b0;
        reset = 1'b0;
        if_ready = 1'b1;
        #1;
        check("post_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        check("post_rst_req_addr", bus.imem_req_addr, 32'h0);
        collect(2, "post_rst");
        if (k == 2) begin
            check("post_rst_pc0", got[0], 32'h0);
            check("post_rst_pc1", got[1], 32'h4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
